// File: rtl/bus_ctrl_pkg.sv
// Shared encodings for the register-bus transfer sequencer.
// Optional instruction counter is enabled by defining BUS_CTRL_ICOUNT_EN.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T1   = 2'b01,
    S_T2   = 2'b10,
    S_T3   = 2'b11
  } state_t;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // LOAD and MOV finish in T1; ADD/SUB need the A/G round trip.
  function automatic logic is_single_cycle(op_t op);
    return (op == OP_LOAD) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/bus_ctrl_decode.sv
// Combinational enable decode from registered state and latched instruction.
// Exactly one bus driver per active cycle: r_out[*], g_out or ext_out.
module bus_ctrl_decode
  import bus_ctrl_pkg::*;
#(
  parameter int NREG = 4,
  localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  state_t          state,
  input  op_t             op,
  input  logic [RW-1:0]   rx,
  input  logic [RW-1:0]   ry,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out,
  output logic            a_in,
  output logic            g_in,
  output logic            g_out,
  output logic            ext_out,
  output logic            alu_sub,
  output logic            done
);

  logic [NREG-1:0] rx_oh, ry_oh;

  for (genvar i = 0; i < NREG; i++) begin : g_oh
    assign rx_oh[i] = (rx == RW'(i));
    assign ry_oh[i] = (ry == RW'(i));
  end

  always_comb begin
    r_in    = '0;
    r_out   = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    ext_out = 1'b0;
    alu_sub = ALU_ADD;
    done    = 1'b0;
    unique case (state)
      S_T1: begin
        case (op)
          OP_LOAD: begin
            ext_out = 1'b1;
            r_in    = rx_oh;
            done    = 1'b1;
          end
          OP_MOV: begin
            r_out = ry_oh;
            r_in  = rx_oh;
            done  = 1'b1;
          end
          default: begin
            r_out = rx_oh;
            a_in  = 1'b1;
          end
        endcase
      end
      S_T2: begin
        r_out   = ry_oh;
        g_in    = 1'b1;
        alu_sub = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      S_T3: begin
        g_out = 1'b1;
        r_in  = rx_oh;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Register-bus transfer sequencer: FSM, instruction latch, enable decode.
// Define BUS_CTRL_ICOUNT_EN to add the 8-bit completed-instruction counter port icount.
module bus_transfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 3,
  localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [RW-1:0]   rx,
  input  logic [RW-1:0]   ry,
  input  logic [W-1:0]    imm,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out,
  output logic            a_in,
  output logic            g_in,
  output logic            g_out,
  output logic            ext_out,
  output logic [W-1:0]    imm_bus,
  output logic            alu_sub,
  output logic            busy,
  output logic            done
`ifdef BUS_CTRL_ICOUNT_EN
  ,
  output logic [7:0]      icount
`endif
);

  typedef struct packed {
    op_t           op;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic [W-1:0]  imm;
  } instr_t;

  state_t state;
  instr_t instr;

  // start is only looked at in IDLE; anything arriving mid-sequence is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      instr <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          instr <= '{op: op_t'(op), rx: rx, ry: ry, imm: imm};
          state <= S_T1;
        end
        S_T1:    state <= is_single_cycle(instr.op) ? S_IDLE : S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign imm_bus = instr.imm;

  bus_ctrl_decode #(.NREG(NREG)) u_decode (
    .state   (state),
    .op      (instr.op),
    .rx      (instr.rx),
    .ry      (instr.ry),
    .r_in    (r_in),
    .r_out   (r_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .ext_out (ext_out),
    .alu_sub (alu_sub),
    .done    (done)
  );

`ifdef BUS_CTRL_ICOUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       icount <= '0;
    else if (done) icount <= icount + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench: register bank + ALU plant on the bus, ISA-level scoreboard of register results.
// Directed enable checks for LOAD/MOV/ADD/SUB, reset mid-op, held start, random stream.
module tb_bus_transfer_ctrl;
  import bus_ctrl_pkg::*;

  localparam int NREG = 4;
  localparam int W    = 3;
  localparam int RW   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      op = '0;
  logic [RW-1:0]   rx = '0, ry = '0;
  logic [W-1:0]    imm = '0;
  logic [NREG-1:0] r_in, r_out;
  logic            a_in, g_in, g_out, ext_out, alu_sub, busy, done;
  logic [W-1:0]    imm_bus;
`ifdef BUS_CTRL_ICOUNT_EN
  logic [7:0]      icount;
`endif

  always #5 clk = ~clk;

  bus_transfer_ctrl #(.NREG(NREG), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rx(rx), .ry(ry), .imm(imm),
    .r_in(r_in), .r_out(r_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
    .ext_out(ext_out), .imm_bus(imm_bus), .alu_sub(alu_sub), .busy(busy), .done(done)
`ifdef BUS_CTRL_ICOUNT_EN
    , .icount(icount)
`endif
  );

  // Plant: register bank and ALU reacting to the enables
  logic [W-1:0] rf [NREG];
  logic [W-1:0] a_q, g_q, bus;
  int           ndrv;

  always_comb begin
    bus  = '0;
    ndrv = 0;
    for (int i = 0; i < NREG; i++) if (r_out[i]) begin bus = rf[i]; ndrv++; end
    if (g_out)   begin bus = g_q;     ndrv++; end
    if (ext_out) begin bus = imm_bus; ndrv++; end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (r_in[i]) rf[i] <= bus;
    if (a_in) a_q <= bus;
    if (g_in) g_q <= alu_sub ? a_q - bus : a_q + bus;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: ISA-level expected register contents
  typedef struct { int rx; logic [W-1:0] val; } sb_t;
  sb_t          sbq[$];
  logic [W-1:0] exp_rf [NREG];

  task automatic sb_push(input logic [1:0] o, input int x, input int y, input logic [W-1:0] im);
    logic [W-1:0] v;
    case (o)
      OP_LOAD: v = im;
      OP_MOV:  v = exp_rf[y];
      OP_ADD:  v = exp_rf[x] + exp_rf[y];
      default: v = exp_rf[x] - exp_rf[y];
    endcase
    sbq.push_back('{rx: x, val: v});
    exp_rf[x] = v;
  endtask

  logic pend = 1'b0;
  always @(negedge clk) begin
    chk("drv_le1", (ndrv <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (pend) begin
      if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        sb_t e;
        e = sbq.pop_front();
        chk($sformatf("R%0d", e.rx), 32'(rf[e.rx]), 32'(e.val));
      end
    end
    pend = done;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && busy; n++) step();
    chk("idle_to", 32'(busy), 32'd0);
  endtask

  // Returns #1 after the accepting edge, i.e. inside T1
  task automatic issue(input logic [1:0] o, input int x, input int y,
                       input logic [W-1:0] im, input bit push);
    wait_idle();
    op = o; rx = RW'(x); ry = RW'(y); imm = im; start = 1'b1;
    if (push) sb_push(o, x, y, im);
    step();
    start = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"}, {r_in, r_out, a_in, g_in, g_out, ext_out, alu_sub}, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1;
    chk_quiet("rst0");
    chk("rst0_imm", 32'(imm_bus), 32'd0);
    step(); step();
    rst = 1'b0;

    for (int i = 0; i < NREG; i++) begin
      issue(OP_LOAD, i, 0, W'(i + 1), 1'b1);
    end

    // LOAD rx=2 imm=5
    issue(OP_LOAD, 2, 0, 3'd5, 1'b1);
    chk("ld_ext", 32'(ext_out), 32'd1);
    chk("ld_rin", 32'(r_in), 32'b0100);
    chk("ld_rout", 32'(r_out), 32'd0);
    chk("ld_imm", 32'(imm_bus), 32'd5);
    chk("ld_done", 32'(done), 32'd1);

    // MOV rx=0 ry=3 with R3=6
    issue(OP_LOAD, 3, 0, 3'd6, 1'b1);
    issue(OP_MOV, 0, 3, 3'd0, 1'b1);
    chk("mov_rout", 32'(r_out), 32'b1000);
    chk("mov_rin", 32'(r_in), 32'b0001);
    chk("mov_done", 32'(done), 32'd1);

    // ADD rx=1 ry=2 with R1=3 R2=6 -> 1
    issue(OP_LOAD, 1, 0, 3'd3, 1'b1);
    issue(OP_LOAD, 2, 0, 3'd6, 1'b1);
    issue(OP_ADD, 1, 2, 3'd0, 1'b1);
    chk("add1_rout", 32'(r_out), 32'b0010);
    chk("add1_ain", 32'(a_in), 32'd1);
    chk("add1_done", 32'(done), 32'd0);
    step();
    chk("add2_rout", 32'(r_out), 32'b0100);
    chk("add2_gin", 32'(g_in), 32'd1);
    chk("add2_sub", 32'(alu_sub), 32'd0);
    step();
    chk("add3_gout", 32'(g_out), 32'd1);
    chk("add3_rin", 32'(r_in), 32'b0010);
    chk("add3_done", 32'(done), 32'd1);

    // SUB rx=1 ry=1 with R1=4, start held high with changing fields
    issue(OP_LOAD, 1, 0, 3'd4, 1'b1);
    wait_idle();
    op = OP_SUB; rx = 2'd1; ry = 2'd1; start = 1'b1;
    sb_push(OP_SUB, 1, 1, 3'd0);
    step();
    op = OP_ADD; rx = 2'd0; ry = 2'd3; imm = 3'd7;
    step();
    chk("sub2_sub", 32'(alu_sub), 32'd1);
    chk("sub2_rout", 32'(r_out), 32'b0010);
    step();
    chk("sub3_rin", 32'(r_in), 32'b0010);
    chk("sub3_done", 32'(done), 32'd1);
    start = 1'b0;
    step();
    chk("sub_idle", 32'(busy), 32'd0);
    step();
    chk("sub_noacc", 32'(busy), 32'd0);

    // Reset in T2 of an ADD: abandoned, nothing written
    issue(OP_ADD, 3, 0, 3'd0, 1'b0);
    step();
    #2 rst = 1'b1;
    #1 chk_quiet("rstmid");
    @(posedge clk); #1;
    chk_quiet("rstmid_e");
    rst = 1'b0;
    issue(OP_LOAD, 3, 0, 3'd2, 1'b1);
    chk("post_rst_ld", 32'(ext_out), 32'd1);

    // Random stream
    for (int k = 0; k < 30; k++) begin
      issue(2'($urandom_range(0, 3)), $urandom_range(0, NREG - 1),
            $urandom_range(0, NREG - 1), W'($urandom), 1'b1);
    end

`ifdef BUS_CTRL_ICOUNT_EN
    wait_idle();
    step();
    rst = 1'b1;
    #1 chk("ic_rst", 32'(icount), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 257; k++) issue(OP_LOAD, k % NREG, 0, W'(k), 1'b1);
    step();
    chk("icount257", 32'(icount), 32'd1);
`endif

    wait_idle();
    for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
